// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store initiator: checks alignment, drives a word-addressed memory over req/ack,
// stalls the pipeline until completion and returns formatted load data with exception flags.
module mem_lsu_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_adel,
    output logic        lsu_ades,
    output logic        lsu_buserr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  lat_size, lat_size_n, lat_lane, lat_lane_n;
    logic        lat_sign, lat_sign_n, lat_load, lat_load_n;
    logic        req_n, we_n, done_n, adel_n, ades_n, buserr_n;
    logic [3:0]  wen_n;
    logic [31:0] addr_n, wdata_n, rdata_n;
    logic        op;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~lo[0];
            default: return (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic sign,
                                             input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   return {{24{sign & b[7]}}, b};
            2'b01:   return {{16{sign & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    assign op        = ex_valid & (ex_load | ex_store);
    assign lsu_stall = ((state == IDLE) & op) | (state == REQ);

    // Next-state and next registered-output computation.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_size_n = lat_size;
        lat_sign_n = lat_sign;
        lat_lane_n = lat_lane;
        lat_load_n = lat_load;
        req_n      = mem_req;
        we_n       = mem_we;
        wen_n      = mem_wen;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        done_n     = 1'b0;
        rdata_n    = 32'd0;
        adel_n     = 1'b0;
        ades_n     = 1'b0;
        buserr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (op && is_aligned(ex_size, ex_addr[1:0])) begin
                    lat_size_n = ex_size;
                    lat_sign_n = ex_sign;
                    lat_lane_n = ex_addr[1:0];
                    lat_load_n = ex_load;
                    req_n      = 1'b1;
                    we_n       = ~ex_load;
                    wen_n      = ex_load ? 4'b0000 : store_wen(ex_size, ex_addr[1:0]);
                    addr_n     = {ex_addr[31:2], 2'b00};
                    wdata_n    = ex_load ? 32'd0 : store_data(ex_size, ex_wdata);
                    state_n    = REQ;
                end else if (op) begin
                    // Misaligned: report the error without touching memory.
                    done_n  = 1'b1;
                    adel_n  = ex_load;
                    ades_n  = ~ex_load;
                    state_n = DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (mem_ack || (cnt == TMO_LAST)) begin
                    req_n    = 1'b0;
                    we_n     = 1'b0;
                    wen_n    = 4'b0000;
                    addr_n   = 32'd0;
                    wdata_n  = 32'd0;
                    done_n   = 1'b1;
                    cnt_n    = 8'd0;
                    state_n  = DONE;
                    if (mem_ack) begin
                        rdata_n = lat_load ? load_fmt(lat_size, lat_sign, lat_lane, mem_rdata) : 32'd0;
                    end else begin
                        buserr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // State, latched op fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            lat_size   <= 2'b00;
            lat_sign   <= 1'b0;
            lat_lane   <= 2'b00;
            lat_load   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wen    <= 4'b0000;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            lsu_done   <= 1'b0;
            lsu_rdata  <= 32'd0;
            lsu_adel   <= 1'b0;
            lsu_ades   <= 1'b0;
            lsu_buserr <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_size   <= lat_size_n;
            lat_sign   <= lat_sign_n;
            lat_lane   <= lat_lane_n;
            lat_load   <= lat_load_n;
            mem_req    <= req_n;
            mem_we     <= we_n;
            mem_wen    <= wen_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            lsu_done   <= done_n;
            lsu_rdata  <= rdata_n;
            lsu_adel   <= adel_n;
            lsu_ades   <= ades_n;
            lsu_buserr <= buserr_n;
        end
    end

endmodule
